// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI master arbiter
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int SPI_DATA_LENGTH = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req bit at or above ptr, with wrap
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       any
);

  localparam int PW = $clog2(NUM_REQ);

  // ptr and k are both below NUM_REQ, so one conditional subtract wraps the sum
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int unsigned k);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(k);
    if (s >= (PW+1)'(NUM_REQ)) begin
      s = s - (PW+1)'(NUM_REQ);
    end
    return s[PW-1:0];
  endfunction

  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any && req[wrap_idx(ptr, k)]) begin
        gnt[wrap_idx(ptr, k)] = 1'b1;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin sharing of one spi_master among NUM_REQ single-word requesters
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_LENGTH = SPI_DATA_LENGTH,
  parameter int TIMEOUT     = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_LENGTH-1:0]         rsp_data,
  output logic                           rsp_err,
  output logic                           m_start,
  output logic [DATA_LENGTH-1:0]         m_data_in,
  input  logic [DATA_LENGTH-1:0]         m_data_out,
  input  logic                           m_busy,
  input  logic                           m_done
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_t           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic [DATA_LENGTH-1:0] data_in_q, data_in_d;
  logic [DATA_LENGTH-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]     gnt;
  logic                   gnt_any;
  logic [PW-1:0]          win_idx;
  logic [DATA_LENGTH-1:0] win_word;
  logic                   grant_now;
  logic                   timeout_hit;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .any (gnt_any)
  );

  always_comb begin
    win_idx  = '0;
    win_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_idx  = PW'(i);
        win_word = req_data[i*DATA_LENGTH +: DATA_LENGTH];
      end
    end
  end

  // the master is never restarted while still busy, e.g. after a reset mid-transfer
  assign grant_now   = gnt_any && !m_busy;
  // compare before increment so the abort lands TIMEOUT+1 cycles after m_start
  assign timeout_hit = (wd_q == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_now) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (m_done || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    wd_d       = wd_q;
    data_in_d  = data_in_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant_now) begin
          owner_d   = win_idx;
          data_in_d = win_word;
        end
      end
      START: wd_d = '0;
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (m_done) begin
          rsp_data_d = m_data_out;
          rsp_err_d  = 1'b0;
        end else if (timeout_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      RESP: ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      owner_q    <= '0;
      wd_q       <= '0;
      data_in_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      wd_q       <= wd_d;
      data_in_q  <= data_in_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    m_start   = 1'b0;
    if (state_q == START) begin
      req_ready[owner_q] = 1'b1;
      m_start            = 1'b1;
    end
    if (state_q == RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign m_data_in = data_in_q;

endmodule
